// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX operand-mux forwarding selects and one-cycle load-use stall.
// Tracks rd of the three older in-flight instrs (D1/D2/D3) and registers sel into EX.
// Ports: clk, rst (sync, active-high); ID inputs id_valid, id_rs1, id_rs2, id_rd,
//   id_reg_we, id_is_load, id_use_pc, id_use_imm, flush;
//   outputs ex_valid, ex_sel_a, ex_sel_b (registered), stall (combinational).
// Sel encoding: 0 regfile, 1 dist-1, 2 dist-2, 3 dist-3, 4 PC/imm.
// Optional FWD_STATS_EN: adds saturating stall_cnt / fwd_cnt outputs.
module fwd_sel_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              id_use_pc,
    input  logic              id_use_imm,
    input  logic              flush,
    output logic              ex_valid,
    output logic [2:0]        ex_sel_a,
    output logic [2:0]        ex_sel_b,
    output logic              stall
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } trk_t;

    trk_t       d1, d2, d3;
    trk_t       d1_nxt;
    logic [2:0] sel_a, sel_b;
    logic [2:0] match_a, match_b;
    logic       enter;

    function automatic logic hit(input trk_t t, input logic [REG_AW-1:0] rs);
        return t.valid && t.we && (t.rd == rs) && (rs != '0);
    endfunction

    // Youngest producer wins.
    function automatic logic [2:0] match_of(input trk_t t1, input trk_t t2,
                                            input trk_t t3,
                                            input logic [REG_AW-1:0] rs);
        logic [2:0] m;
        m = 3'd0;
        if (hit(t1, rs))      m = 3'd1;
        else if (hit(t2, rs)) m = 3'd2;
        else if (hit(t3, rs)) m = 3'd3;
        return m;
    endfunction

    always_comb begin
        match_a = match_of(d1, d2, d3, id_rs1);
        match_b = match_of(d1, d2, d3, id_rs2);
        sel_a   = id_use_pc  ? 3'd4 : match_a;
        sel_b   = id_use_imm ? 3'd4 : match_b;
    end

    // A load at distance 1 cannot forward yet; hold one cycle so it
    // reaches distance 2 (MEM/WB) before the consumer enters EX.
    assign stall = id_valid && !flush && d1.valid && d1.ld && d1.we &&
                   (d1.rd != '0) &&
                   (((d1.rd == id_rs1) && !id_use_pc) ||
                    ((d1.rd == id_rs2) && !id_use_imm));

    assign enter = id_valid && !stall && !flush;

    always_comb begin
        d1_nxt = '0;
        if (enter) begin
            d1_nxt.valid = 1'b1;
            d1_nxt.rd    = id_rd;
            d1_nxt.we    = id_reg_we;
            d1_nxt.ld    = id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            ex_valid <= 1'b0;
            ex_sel_a <= 3'd0;
            ex_sel_b <= 3'd0;
        end else begin
            d3       <= d2;
            d2       <= d1;
            d1       <= d1_nxt;
            ex_valid <= enter;
            ex_sel_a <= enter ? sel_a : 3'd0;
            ex_sel_b <= enter ? sel_b : 3'd0;
        end
    end

`ifdef FWD_STATS_EN
    logic [1:0]     fwd_inc;
    logic [CNT_W:0] fwd_sum;
    logic [CNT_W:0] stall_sum;

    always_comb begin
        fwd_inc = 2'd0;
        if (ex_valid && (ex_sel_a inside {[3'd1:3'd3]}))
            fwd_inc = fwd_inc + 2'd1;
        if (ex_valid && (ex_sel_b inside {[3'd1:3'd3]}))
            fwd_inc = fwd_inc + 2'd1;
    end

    assign fwd_sum   = {1'b0, fwd_cnt} + {{(CNT_W-1){1'b0}}, fwd_inc};
    assign stall_sum = {1'b0, stall_cnt} + {{CNT_W{1'b0}}, stall};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            stall_cnt <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
            fwd_cnt   <= fwd_sum[CNT_W]   ? '1 : fwd_sum[CNT_W-1:0];
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb_fwd_sel_ctrl: directed scenarios plus random traffic checked against
// a history-list reference model of in-flight producers.
module tb_fwd_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_we, id_is_load, id_use_pc, id_use_imm, flush;
    logic       ex_valid;
    logic [2:0] ex_sel_a, ex_sel_b;
    logic       stall;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    fwd_sel_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_reg_we  (id_reg_we),
        .id_is_load (id_is_load),
        .id_use_pc  (id_use_pc),
        .id_use_imm (id_use_imm),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_sel_a   (ex_sel_a),
        .ex_sel_b   (ex_sel_b),
        .stall      (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: list of older instructions, index 0 = one ahead of ID.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } prod_t;

    prod_t    hist[3];
    bit       m_ev;
    bit [2:0] m_sa, m_sb;
    longint   m_scnt, m_fcnt;
    logic     last_stall;

    function automatic bit [2:0] youngest(input bit [4:0] rs);
        for (int n = 0; n < 3; n++)
            if (rs != 0 && hist[n].v && hist[n].we && hist[n].rd == rs)
                return 3'(n + 1);
        return 3'd0;
    endfunction

    function automatic bit fwd_src(input bit [2:0] s);
        return s >= 1 && s <= 3;
    endfunction

    task automatic step(input bit r, input bit v, input bit [4:0] a,
                        input bit [4:0] b, input bit [4:0] d, input bit we,
                        input bit ld, input bit pc, input bit imm,
                        input bit fl);
        bit     e_stall, go;
        bit     dep_a, dep_b;
        prod_t  p;
        @(negedge clk);
        rst = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_rd = d;
        id_reg_we = we; id_is_load = ld; id_use_pc = pc; id_use_imm = imm;
        flush = fl;
        #1;
        p = hist[0];
        dep_a = !pc && a == p.rd;
        dep_b = !imm && b == p.rd;
        e_stall = v && !fl && p.v && p.ld && p.we && p.rd != 0 &&
                  (dep_a || dep_b);
        last_stall = stall;
        check("stall", 32'(stall), 32'(e_stall));
        go = v && !e_stall && !fl;
        if (r) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
            m_scnt = 0; m_fcnt = 0;
            m_ev = 0; m_sa = 0; m_sb = 0;
        end else begin
            m_scnt = m_scnt + (e_stall ? 1 : 0);
            m_fcnt = m_fcnt + (m_ev && fwd_src(m_sa) ? 1 : 0)
                            + (m_ev && fwd_src(m_sb) ? 1 : 0);
            m_ev = go;
            m_sa = !go ? 3'd0 : pc  ? 3'd4 : youngest(a);
            m_sb = !go ? 3'd0 : imm ? 3'd4 : youngest(b);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = go ? '{1, d, we, ld} : '{0, 0, 0, 0};
        end
        @(posedge clk);
        #1;
        check("ex_valid", 32'(ex_valid), 32'(m_ev));
        check("ex_sel_a", 32'(ex_sel_a), 32'(m_sa));
        check("ex_sel_b", 32'(ex_sel_b), 32'(m_sb));
`ifdef FWD_STATS_EN
        check("stall_cnt", stall_cnt, 32'(m_scnt));
        check("fwd_cnt", fwd_cnt, 32'(m_fcnt));
`endif
    endtask

    // step args: rst valid rs1 rs2 rd we ld pc imm flush
    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
        m_ev = 0; m_sa = 0; m_sb = 0; m_scnt = 0; m_fcnt = 0;
        rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_we = 0; id_is_load = 0; id_use_pc = 0; id_use_imm = 0;
        flush = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_sel", 32'({ex_sel_a, ex_sel_b}), 0);
        nop();
        check("rst_stall", 32'(last_stall), 0);

        // add x5 ; add x6,x5,x5
        step(0, 1, 1, 2, 5, 1, 0, 0, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0, 0);
        check("b2b_stall", 32'(last_stall), 0);
        check("b2b_sel_a", 32'(ex_sel_a), 1);
        check("b2b_sel_b", 32'(ex_sel_b), 1);

        // x5 at dist 3 and dist 1
        step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        step(0, 1, 5, 0, 10, 1, 0, 0, 0, 0);
        check("young_sel_a", 32'(ex_sel_a), 1);

        // lw x7 ; add x8,x7,x0
        nop(); nop(); nop();
        step(0, 1, 1, 0, 7, 1, 1, 0, 0, 0);
        step(0, 1, 7, 0, 8, 1, 0, 0, 0, 0);
        check("lu_stall", 32'(last_stall), 1);
        check("lu_bubble", 32'(ex_valid), 0);
        step(0, 1, 7, 0, 8, 1, 0, 0, 0, 0);
        check("lu_stall_once", 32'(last_stall), 0);
        check("lu_sel_a", 32'(ex_sel_a), 2);
        check("lu_sel_b", 32'(ex_sel_b), 0);

        // lw x7 ; consumer flushed in the hazard cycle
        nop(); nop(); nop();
        step(0, 1, 1, 0, 7, 1, 1, 0, 0, 0);
        step(0, 1, 7, 7, 8, 1, 0, 0, 0, 1);
        check("fl_stall", 32'(last_stall), 0);
        check("fl_bubble", 32'(ex_valid), 0);

        // writer rd=x0 never forwards
        step(0, 1, 1, 1, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        check("x0_stall", 32'(last_stall), 0);
        check("x0_sel", 32'({ex_sel_a, ex_sel_b}), 0);

        // PC/imm operands override matches and suppress stall
        nop(); nop(); nop();
        step(0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 1, 1, 0);
        check("pcimm_stall", 32'(last_stall), 0);
        check("pcimm_sel_a", 32'(ex_sel_a), 4);
        check("pcimm_sel_b", 32'(ex_sel_b), 4);

        // reset in the middle of a load-use stall
        step(0, 1, 0, 0, 7, 1, 1, 0, 0, 0);
        step(1, 1, 7, 0, 8, 1, 0, 0, 0, 0);
        check("rstm_ex_valid", 32'(ex_valid), 0);
        check("rstm_sel", 32'({ex_sel_a, ex_sel_b}), 0);
        step(0, 1, 7, 0, 8, 1, 0, 0, 0, 0);
        check("rstm_stall", 32'(last_stall), 0);
        check("rstm_sel_a", 32'(ex_sel_a), 0);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(63, 0) == 0),
                 ($urandom_range(7, 0) != 0),
                 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                 5'($urandom_range(3, 0)),
                 ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0),
                 ($urandom_range(4, 0) == 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(9, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
